// File: rtl/ir_nec_pkg.sv
// Shared types and timing constants for the NEC infrared receiver.
// All durations are expressed in 10 us ticks.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_MARK,
    ST_LEAD_SPACE,
    ST_BIT_MARK,
    ST_BIT_SPACE,
    ST_STOP_MARK,
    ST_RPT_MARK,
    ST_PUBLISH
  } state_t;

  localparam int TICK_HZ = 100_000;

  localparam int NOM_LEAD_MARK  = 900;
  localparam int NOM_LEAD_SPACE = 450;
  localparam int NOM_RPT_SPACE  = 225;
  localparam int NOM_BIT_MARK   = 56;
  localparam int NOM_ZERO_SPACE = 56;
  localparam int NOM_ONE_SPACE  = 169;

  localparam int                DUR_W      = 12;
  localparam logic [DUR_W-1:0]  DUR_MAX    = 12'hFFF;
  localparam int                IDLE_W     = 14;
  localparam int                HOLD_TICKS = 12000;

  // Lower (upper=0) or upper (upper=1) edge of the acceptance window around nom.
  function automatic logic [DUR_W-1:0] win_bound(input int nom, input int tol_pct,
                                                 input bit upper);
    int pct;
    pct = upper ? (100 + tol_pct) : (100 - tol_pct);
    return DUR_W'((nom * pct) / 100);
  endfunction

  function automatic logic in_window(input logic [DUR_W-1:0] d,
                                     input logic [DUR_W-1:0] lo,
                                     input logic [DUR_W-1:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/ir_nec_rx_if.sv
// Result handshake between the NEC receiver and its command consumer.
interface ir_nec_rx_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic [7:0]  addr;
  logic [7:0]  cmd;
  logic        is_repeat;

  modport master (output valid, data, addr, cmd, is_repeat, input ready);
  modport slave  (input valid, data, addr, cmd, is_repeat, output ready);
endinterface

// File: rtl/ir_glitch_filter.sv
// Synchronises the raw receiver output, normalises it to "mark", and only
// accepts a new level after it has persisted for GLITCH_CYC samples.
module ir_glitch_filter #(
  parameter int GLITCH_CYC    = 64,
  parameter bit IR_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ir_in,
  output logic mark_rise,
  output logic mark_fall
);

  localparam int   CW         = $clog2(GLITCH_CYC + 1);
  localparam logic IDLE_LEVEL = IR_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [1:0]    sync_q;
  logic          raw_mark;
  logic          mark_q;
  logic [CW-1:0] cnt_q;

  assign raw_mark = IR_ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

  // Any sample agreeing with the accepted level restarts the persistence count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= {2{IDLE_LEVEL}};
      cnt_q     <= '0;
      mark_q    <= 1'b0;
      mark_rise <= 1'b0;
      mark_fall <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], ir_in};
      mark_rise <= 1'b0;
      mark_fall <= 1'b0;
      if (raw_mark == mark_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(GLITCH_CYC - 1)) begin
        cnt_q     <= '0;
        mark_q    <= raw_mark;
        mark_rise <= raw_mark;
        mark_fall <= ~raw_mark;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ir_nec_rx.sv
// NEC infrared frame and repeat-code decoder with inverse-byte checking and
// a valid/ready result register.
module ir_nec_rx
  import ir_nec_pkg::*;
#(
  parameter int CLK_HZ        = 25_000_000,
  parameter int TOL_PCT       = 25,
  parameter int GLITCH_CYC    = 64,
  parameter bit IR_ACTIVE_LOW = 1'b1,
  parameter bit CHECK_INV     = 1'b1,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        ir_in,
  ir_nec_rx_if.master bus,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DUR_W-1:0] LM_LO = win_bound(NOM_LEAD_MARK,  TOL_PCT, 1'b0);
  localparam logic [DUR_W-1:0] LM_HI = win_bound(NOM_LEAD_MARK,  TOL_PCT, 1'b1);
  localparam logic [DUR_W-1:0] LS_LO = win_bound(NOM_LEAD_SPACE, TOL_PCT, 1'b0);
  localparam logic [DUR_W-1:0] LS_HI = win_bound(NOM_LEAD_SPACE, TOL_PCT, 1'b1);
  localparam logic [DUR_W-1:0] RS_LO = win_bound(NOM_RPT_SPACE,  TOL_PCT, 1'b0);
  localparam logic [DUR_W-1:0] RS_HI = win_bound(NOM_RPT_SPACE,  TOL_PCT, 1'b1);
  localparam logic [DUR_W-1:0] BM_LO = win_bound(NOM_BIT_MARK,   TOL_PCT, 1'b0);
  localparam logic [DUR_W-1:0] BM_HI = win_bound(NOM_BIT_MARK,   TOL_PCT, 1'b1);
  localparam logic [DUR_W-1:0] ZS_LO = win_bound(NOM_ZERO_SPACE, TOL_PCT, 1'b0);
  localparam logic [DUR_W-1:0] ZS_HI = win_bound(NOM_ZERO_SPACE, TOL_PCT, 1'b1);
  localparam logic [DUR_W-1:0] OS_LO = win_bound(NOM_ONE_SPACE,  TOL_PCT, 1'b0);
  localparam logic [DUR_W-1:0] OS_HI = win_bound(NOM_ONE_SPACE,  TOL_PCT, 1'b1);

  logic              mark_rise;
  logic              mark_fall;
  logic [PW-1:0]     pre_q;
  logic              tick;
  logic [DUR_W-1:0]  dur_q;
  logic              dur_sat;

  state_t            state_q;
  state_t            next_state;
  logic [4:0]        bit_idx_q;
  logic [31:0]       shift_q;
  logic              rpt_q;
  logic [31:0]       last_q;
  logic              have_last_q;
  logic [IDLE_W-1:0] idle_q;

  logic              valid_q;
  logic [31:0]       data_q;
  logic              rpt_out_q;
  logic              err_q;
  logic [7:0]        err_cnt_q;

  logic              decode_err;
  logic              shift_en;
  logic              shift_val;
  logic              bit_clr;
  logic              set_rpt;
  logic              inv_ok;
  logic              pub_ok;
  logic              pub_err;
  logic [31:0]       pub_data;
  logic              pub_rpt;
  logic              load;
  logic              overrun;
  logic              err_evt;

  ir_glitch_filter #(
    .GLITCH_CYC    (GLITCH_CYC),
    .IR_ACTIVE_LOW (IR_ACTIVE_LOW)
  ) u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir_in     (ir_in),
    .mark_rise (mark_rise),
    .mark_fall (mark_fall)
  );

  assign tick    = (pre_q == PW'(DIV - 1));
  assign dur_sat = (dur_q == DUR_MAX);

  // dur always holds the length of the segment that the current edge terminates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q <= '0;
      dur_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
      if (mark_rise || mark_fall) begin
        dur_q <= '0;
      end else if (tick && !dur_sat) begin
        dur_q <= dur_q + 12'd1;
      end
    end
  end

  always_comb begin
    next_state = state_q;
    decode_err = 1'b0;
    shift_en   = 1'b0;
    shift_val  = 1'b0;
    bit_clr    = 1'b0;
    set_rpt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mark_rise) next_state = ST_LEAD_MARK;
      end
      ST_LEAD_MARK: begin
        if (mark_fall) begin
          if (in_window(dur_q, LM_LO, LM_HI)) next_state = ST_LEAD_SPACE;
          else                                decode_err = 1'b1;
        end
      end
      ST_LEAD_SPACE: begin
        if (mark_rise) begin
          if (in_window(dur_q, LS_LO, LS_HI)) begin
            next_state = ST_BIT_MARK;
            bit_clr    = 1'b1;
          end else if (REPEAT_EN && in_window(dur_q, RS_LO, RS_HI)) begin
            next_state = ST_RPT_MARK;
            set_rpt    = 1'b1;
          end else begin
            decode_err = 1'b1;
          end
        end
      end
      ST_BIT_MARK: begin
        if (mark_fall) begin
          if (in_window(dur_q, BM_LO, BM_HI)) next_state = ST_BIT_SPACE;
          else                                decode_err = 1'b1;
        end
      end
      ST_BIT_SPACE: begin
        if (mark_rise) begin
          if (in_window(dur_q, ZS_LO, ZS_HI)) begin
            shift_en = 1'b1;
          end else if (in_window(dur_q, OS_LO, OS_HI)) begin
            shift_en  = 1'b1;
            shift_val = 1'b1;
          end else begin
            decode_err = 1'b1;
          end
          if (shift_en) next_state = (bit_idx_q == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
        end
      end
      ST_STOP_MARK, ST_RPT_MARK: begin
        if (mark_fall) begin
          if (in_window(dur_q, BM_LO, BM_HI)) next_state = ST_PUBLISH;
          else                                decode_err = 1'b1;
        end
      end
      ST_PUBLISH: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase

    if (dur_sat && (state_q != ST_IDLE) && (state_q != ST_PUBLISH)) decode_err = 1'b1;

    if (decode_err) begin
      next_state = ST_IDLE;
      shift_en   = 1'b0;
      bit_clr    = 1'b0;
      set_rpt    = 1'b0;
    end

    // Disabling silently discards whatever was in flight.
    if (!enable) begin
      next_state = ST_IDLE;
      decode_err = 1'b0;
      shift_en   = 1'b0;
      bit_clr    = 1'b0;
      set_rpt    = 1'b0;
    end
  end

  assign inv_ok = !CHECK_INV ||
                  ((shift_q[15:8] == ~shift_q[7:0]) && (shift_q[31:24] == ~shift_q[23:16]));

  always_comb begin
    pub_ok   = 1'b0;
    pub_err  = 1'b0;
    pub_data = shift_q;
    pub_rpt  = 1'b0;
    if ((state_q == ST_PUBLISH) && enable) begin
      if (rpt_q) begin
        if (have_last_q) begin
          pub_ok   = 1'b1;
          pub_data = last_q;
          pub_rpt  = 1'b1;
        end else begin
          pub_err = 1'b1;
        end
      end else if (inv_ok) begin
        pub_ok = 1'b1;
      end else begin
        pub_err = 1'b1;
      end
    end
  end

  assign load    = pub_ok && (!valid_q || bus.ready);
  assign overrun = pub_ok && !load;
  assign err_evt = decode_err || pub_err || overrun;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rpt_q     <= 1'b0;
    end else begin
      state_q <= next_state;
      if (bit_clr) begin
        bit_idx_q <= '0;
        rpt_q     <= 1'b0;
      end else if (shift_en) begin
        bit_idx_q <= bit_idx_q + 5'd1;
        shift_q   <= {shift_val, shift_q[31:1]};
      end
      if (set_rpt) rpt_q <= 1'b1;
    end
  end

  // A remembered frame expires once no decode has succeeded for HOLD_TICKS.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q      <= '0;
      have_last_q <= 1'b0;
      idle_q      <= '0;
    end else begin
      if (pub_ok) begin
        idle_q <= '0;
      end else if (tick && (idle_q != {IDLE_W{1'b1}})) begin
        idle_q <= idle_q + 14'd1;
      end
      if (pub_ok && !rpt_q) begin
        last_q      <= shift_q;
        have_last_q <= 1'b1;
      end else if (idle_q >= IDLE_W'(HOLD_TICKS)) begin
        have_last_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      rpt_out_q <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (load) begin
        valid_q   <= 1'b1;
        data_q    <= pub_data;
        rpt_out_q <= pub_rpt;
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
      err_q <= err_evt;
      if (err_evt && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.valid     = valid_q;
  assign bus.data      = data_q;
  assign bus.addr      = data_q[7:0];
  assign bus.cmd       = data_q[23:16];
  assign bus.is_repeat = rpt_out_q;
  assign err           = err_q;
  assign err_cnt       = err_cnt_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/ir_nec_rx.md
# ir_nec_rx

Parametrised NEC infrared receiver, the successor to the fixed-function IR decoder. It filters the raw demodulator output and measures mark/space durations on a 10 µs tick. It decodes 32-bit NEC frames and repeat codes, checks the inverted address and command bytes, and presents results on a valid/ready handshake. It sits between a board GPIO carrying a TSOP-style receiver output and any command consumer (LED/debug logic, CPU register block).

## Interface
- `CLK_HZ`, 25_000_000, clock frequency; must be a multiple of 100_000.
- `TOL_PCT`, 25, ± tolerance applied to every nominal duration.
- `GLITCH_CYC`, 64, consecutive clk cycles a new input level must persist before it is accepted (≥1).
- `IR_ACTIVE_LOW`, 1, mark is `ir_in==0` when 1, and `ir_in==1` when 0.
- `CHECK_INV`, 1, enables rejection of frames whose byte1≠~byte0 or byte3≠~byte2.
- `REPEAT_EN`, 1, enables repeat-code decoding.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `enable` in 1: decoder runs when 1.
- `ir_in` in 1: raw asynchronous receiver output.
- `valid` out 1: result available.
- `ready` in 1: consumer accepts the result when `valid&&ready`.
- `data` out 32: raw frame; first received bit is `data[0]`.
- `addr` out 8: `data[7:0]`.
- `cmd` out 8: `data[23:16]`.
- `is_repeat` out 1: result came from a repeat code.
- `err` out 1: one-cycle pulse per rejected frame or overrun.
- `err_cnt` out 8: saturating error count.
- `busy` out 1: FSM is not in IDLE.

## Operation
- Input path: 2-FF synchroniser, then polarity normalisation to `mark`. A glitch filter updates filtered `mark` only after `GLITCH_CYC` consecutive equal samples.
- Tick: prescaler divides `clk` by `CLK_HZ/100_000`, giving 10 µs. `dur` is a 12-bit saturating tick counter, cleared on every filtered edge.
- Windows, in ticks: `lo = nom*(100-TOL_PCT)/100`, `hi = nom*(100+TOL_PCT)/100`, computed at elaboration. Nominal values: leader mark 900, leader space 450, repeat space 225, bit mark 56, zero space 56, one space 169. A duration matches when `lo ≤ dur ≤ hi`.
- FSM states:
  - IDLE → LEAD_MARK on a mark rising edge.
  - LEAD_MARK → LEAD_SPACE at mark end if the leader-mark window is met.
  - LEAD_SPACE → BIT_MARK (bit index 0) if the space is in the leader window. It goes → RPT_MARK if the space is in the repeat window and `REPEAT_EN`.
  - BIT_MARK → BIT_SPACE at mark end when in the bit-mark window.
  - BIT_SPACE shifts in 0 or 1 at the next mark start. After bit 31 it goes → STOP_MARK; otherwise → BIT_MARK.
  - STOP_MARK and RPT_MARK → PUBLISH at mark end when in the bit-mark window.
  - PUBLISH → IDLE after one cycle.
- Any out-of-window duration, or `dur` saturating (≥ 4095 ticks) in a non-IDLE state: abort to IDLE, `err` pulse, `err_cnt`+1.
- PUBLISH with a frame:
  - Inverse check fails (with `CHECK_INV`): error, and `have_last` is unchanged.
  - Otherwise the frame is latched as `last`, `have_last`=1, and `idle_cnt` is cleared.
- PUBLISH with a repeat:
  - `have_last`=0: error.
  - Otherwise `data` is the same as `last` and `is_repeat`=1.
- `have_last` clears after 12000 ticks (120 ms) without a successful publish. `idle_cnt` is 14-bit and saturates.
- Output register: loaded only when `!valid || ready`. `valid` stays high until the handshake. A publish while `valid&&!ready` drops the new result and is treated as an error (overrun); the held result is unchanged.
- `enable`=0: FSM forced to IDLE, partial frame discarded, no error. The output register and `valid` are unaffected.

## Timing
- Reset values: `valid`=0, `data`=0, `addr`=0, `cmd`=0, `is_repeat`=0, `err`=0, `err_cnt`=0, `busy`=0. Reset also clears FSM=IDLE, `have_last`=0, filter output=space, and all counters.
- Latency: raw `ir_in` edge to filtered edge is 2+`GLITCH_CYC` cycles. The final filtered edge reaches PUBLISH 1 cycle later, and `valid` rises the cycle after that.
- `err` is asserted exactly 1 cycle per event. `err_cnt` holds at 255.
- A consume and a new publish in the same cycle: the new result is loaded and `valid` stays 1; this is not an overrun.
- Reset mid-frame: everything returns to reset values on the next clock edge.

## Structure
- Package `ir_nec_pkg`: state enum, nominal durations in ticks, tick rate constant, and the window lo/hi function.
- Sub-module `ir_glitch_filter`: synchroniser, polarity, and persistence counter, parameterised by `GLITCH_CYC` and `IR_ACTIVE_LOW`.

## Test plan
- Hold `rst_n`=0 for 3 cycles with the input toggling → all outputs at reset values and `busy`=0.
- Send NEC frame addr 0x04, cmd 0x08 (`data`=0xF708FB04) with `ready`=1 → one `valid` with `addr`=0x04, `cmd`=0x08, `is_repeat`=0 and `err_cnt`=0.
- Send the same frame, then a repeat code 40 ms later → second `valid` with `data`=0xF708FB04 and `is_repeat`=1. A repeat code sent after reset alone → no `valid`, `err_cnt`=1.
- Send `data`=0xF608FB04 (bad ~cmd) → no `valid`, `err_cnt`=1. Repeat with `CHECK_INV`=0 → `valid` with `cmd`=0x08.
- Hold `ready`=0 and send two frames, 0xF708FB04 then 0xFE01FB04 → `data` holds 0xF708FB04 and `err_cnt`=1. Raising `ready` consumes it, and `valid` falls on the next cycle.
- Inject 1 µs low glitches (25 cycles < 64) during idle and spaces → decode unaffected. Drop `enable` at bit 10 → `busy`=0, no `valid`, no error.
